// File: rtl/alu_uart_controller_pkg.sv
// Shared opcode encodings, FSM state type and defaults for the ALU/UART sequencer.
// ALU_FLAGS_TX_EN adds the flag-byte states to the state type.
package alu_uart_controller_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_OP_DEF   = 6;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;

  localparam logic [7:0] ERR_CODE_DEF = 8'hEE;

  typedef enum logic [2:0] {
    ST_WAIT_A   = 3'd0,
    ST_WAIT_B   = 3'd1,
    ST_WAIT_OP  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SEND_RES = 3'd4,
`ifdef ALU_FLAGS_TX_EN
    ST_WAIT_TX  = 3'd5,
    ST_SEND_FLG = 3'd6,
    ST_WAIT_FLG = 3'd7
`else
    ST_WAIT_TX  = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/alu_uart_controller_op_decoder.sv
// Combinational check that an opcode belongs to the supported ALU instruction set.
module alu_op_decoder
  import alu_uart_controller_pkg::*;
#(
  parameter int unsigned NB_OP = NB_OP_DEF
) (
  input  logic [NB_OP-1:0] i_op,
  output logic             o_valid
);

  always_comb begin
    o_valid = 1'b0;
    case (i_op)
      NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
      NB_OP'(OP_XOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL), NB_OP'(OP_NOR): o_valid = 1'b1;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_uart_controller.sv
// Sequencer between UART RX/TX and the ALU: collects A, B, OP, captures the result, sends it back.
// Define ALU_FLAGS_TX_EN to follow each result byte with a {CARRY,NEG,ZERO} flags byte.
module alu_uart_controller
  import alu_uart_controller_pkg::*;
#(
  parameter int unsigned        NB_DATA       = NB_DATA_DEF,
  parameter int unsigned        NB_OP         = NB_OP_DEF,
  parameter int unsigned        TIMEOUT_TICKS = 1000000,
  parameter logic [NB_DATA-1:0] ERR_CODE      = NB_DATA'(ERR_CODE_DEF)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_A,
  output logic [NB_DATA-1:0] o_alu_B,
  output logic [NB_OP-1:0]   o_alu_OP,
  input  logic [NB_DATA-1:0] i_alu_RES,
  input  logic               i_alu_ZERO,
  input  logic               i_alu_NEG,
  input  logic               i_alu_CARRY,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int unsigned       CNT_W    = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             op_hi_ok;
  logic             op_valid_c;
  logic             accepting_c;

`ifdef ALU_FLAGS_TX_EN
  logic [NB_DATA-1:0] flg_byte;
`else
  logic unused_flags;
  assign unused_flags = ^{i_alu_ZERO, i_alu_NEG, i_alu_CARRY};
`endif

  alu_op_decoder #(.NB_OP(NB_OP)) u_op_decoder (
    .i_op    (o_alu_OP),
    .o_valid (op_valid_c)
  );

  assign accepting_c = (state == ST_WAIT_A) || (state == ST_WAIT_B) || (state == ST_WAIT_OP);

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_WAIT_A;
      tmo_cnt    <= '0;
      op_hi_ok   <= 1'b0;
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_OP   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
`ifdef ALU_FLAGS_TX_EN
      flg_byte   <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_overrun  <= i_rx_done && !accepting_c;
      case (state)
        ST_WAIT_A: begin
          tmo_cnt <= '0;
          if (i_rx_done) begin
            o_alu_A <= i_rx_data;
            o_busy  <= 1'b1;
            state   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            o_alu_B <= i_rx_data;
            tmo_cnt <= '0;
            state   <= ST_WAIT_OP;
          end else if (tmo_cnt == CNT_LAST) begin
            tmo_cnt <= '0;
            o_busy  <= 1'b0;
            state   <= ST_WAIT_A;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_OP <= i_rx_data[NB_OP-1:0];
            op_hi_ok <= (i_rx_data[NB_DATA-1:NB_OP] == '0);
            tmo_cnt  <= '0;
            state    <= ST_EXEC;
          end else if (tmo_cnt == CNT_LAST) begin
            tmo_cnt <= '0;
            o_busy  <= 1'b0;
            state   <= ST_WAIT_A;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          // ALU inputs have been stable since the OP byte; capture and arm the TX pulse.
          o_tx_data  <= (op_valid_c && op_hi_ok) ? i_alu_RES : ERR_CODE;
`ifdef ALU_FLAGS_TX_EN
          flg_byte   <= (op_valid_c && op_hi_ok) ?
                        NB_DATA'({i_alu_CARRY, i_alu_NEG, i_alu_ZERO}) : '0;
`endif
          o_tx_start <= 1'b1;
          state      <= ST_SEND_RES;
        end
        ST_SEND_RES: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
`ifdef ALU_FLAGS_TX_EN
            o_tx_data  <= flg_byte;
            o_tx_start <= 1'b1;
            state      <= ST_SEND_FLG;
`else
            o_busy <= 1'b0;
            state  <= ST_WAIT_A;
`endif
          end
        end
`ifdef ALU_FLAGS_TX_EN
        ST_SEND_FLG: begin
          state <= ST_WAIT_FLG;
        end
        ST_WAIT_FLG: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= ST_WAIT_A;
          end
        end
`endif
        default: begin
          o_busy <= 1'b0;
          state  <= ST_WAIT_A;
        end
      endcase
    end
  end

endmodule
